// File: rtl/lock_pkg.sv
// Shared definitions for the press-sequence combination lock.
//   NUM_BTN       number of physical buttons feeding the lock
//   DIGIT_W       width of one code digit (button index)
//   state_t       FSM state type, with IDLE/ENTRY/CHECK/OPEN/LOCKOUT encodings
//   btn_to_digit  button pulse vector -> digit index (meaningful only for one-hot input)
//   max3          largest of three cycle counts, used to size the shared timer
package lock_pkg;

    localparam int NUM_BTN = 4;
    localparam int DIGIT_W = 2;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t ENTRY   = 3'd1;
    localparam state_t CHECK   = 3'd2;
    localparam state_t OPEN    = 3'd3;
    localparam state_t LOCKOUT = 3'd4;

    function automatic logic [DIGIT_W-1:0] btn_to_digit(input logic [NUM_BTN-1:0] btn);
        logic [DIGIT_W-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn[i]) d = DIGIT_W'(i);
        end
        return d;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the entry-timeout, open and lockout phases.
//   clk       system clock
//   rst_n     synchronous active-low reset (count returns to 0)
//   load      load load_val this cycle (takes priority over counting)
//   load_val  value loaded into the counter
//   expired   high in the last cycle of a loaded interval: the coming edge
//             takes the count to 0 (also high while idle at 0)
// The counter never wraps; it holds at 0 once there.
module lock_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flagging the 1 -> 0 step makes a loaded value of N last exactly N cycles.
    assign expired = (count_q <= WIDTH'(1));

endmodule

// File: rtl/press_sequence_lock.sv
// Combination lock driven by one-cycle debounced button press pulses.
//   clk          system clock
//   rst_n        synchronous active-low reset
//   btn_pulse    one-cycle press pulses, bit i = button i
//   code         expected sequence, digit k = code[2k+1:2k], digit 0 pressed first
//   unlocked     high while the lock is open
//   error_pulse  one-cycle pulse per failed entry
//   locked_out   high while presses are ignored after repeated failures
//   entry_count  presses accepted in the current entry
// An entry always collects SEQ_LEN presses before judging, so the user gets
// no hint about which digit was wrong.
module press_sequence_lock
    import lock_pkg::*;
#(
    parameter int SEQ_LEN        = 4,
    parameter int ENTRY_TIMEOUT  = 250_000_000,
    parameter int OPEN_CYCLES    = 500_000_000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1_500_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BTN-1:0]     btn_pulse,
    input  logic [2*SEQ_LEN-1:0]   code,
    output logic                   unlocked,
    output logic                   error_pulse,
    output logic                   locked_out,
    output logic [3:0]             entry_count
);

    localparam int MAX_CYC = max3(ENTRY_TIMEOUT, OPEN_CYCLES, LOCKOUT_CYCLES);
    localparam int TIMER_W = $clog2(64'(MAX_CYC) + 64'd1);
    localparam int FAIL_W  = (MAX_FAILS < 2) ? 1 : $clog2(MAX_FAILS + 1);

    state_t                 state_q, state_d;
    logic [2*SEQ_LEN-1:0]   code_q, code_d;
    logic                   mismatch_q, mismatch_d;
    logic [3:0]             entry_count_q, entry_count_d;
    logic [FAIL_W-1:0]      fail_cnt_q, fail_cnt_d, fail_cnt_inc;
    logic                   unlocked_q, unlocked_d;
    logic                   error_pulse_q, error_pulse_d;
    logic                   locked_out_q, locked_out_d;

    logic                   timer_load;
    logic [TIMER_W-1:0]     timer_load_val;
    logic                   timer_expired;

    logic                   press;
    logic                   digit_ok;
    logic                   last_press;
    logic [DIGIT_W-1:0]     expect_digit;

    lock_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .expired  (timer_expired)
    );

    // The first digit comes straight from the code input because code_q is
    // only captured on that same press.
    always_comb begin
        expect_digit = code[DIGIT_W-1:0];
        if (state_q == ENTRY) begin
            for (int k = 0; k < SEQ_LEN; k++) begin
                if (entry_count_q == 4'(k)) expect_digit = code_q[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // A multi-button pulse is a press of an invalid digit: it counts but never matches.
    assign press        = |btn_pulse;
    assign digit_ok     = $onehot(btn_pulse) && (btn_to_digit(btn_pulse) == expect_digit);
    assign last_press   = (entry_count_q == 4'(SEQ_LEN - 1));
    assign fail_cnt_inc = fail_cnt_q + FAIL_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mismatch_q    <= 1'b0;
            entry_count_q <= '0;
            fail_cnt_q    <= '0;
            unlocked_q    <= 1'b0;
            error_pulse_q <= 1'b0;
            locked_out_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mismatch_q    <= mismatch_d;
            entry_count_q <= entry_count_d;
            fail_cnt_q    <= fail_cnt_d;
            unlocked_q    <= unlocked_d;
            error_pulse_q <= error_pulse_d;
            locked_out_q  <= locked_out_d;
        end
    end

    // Latched code is data only; it is always rewritten before it is read.
    always_ff @(posedge clk) begin
        code_q <= code_d;
    end

    // Next-state and entry bookkeeping
    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        mismatch_d     = mismatch_q;
        entry_count_d  = entry_count_q;
        fail_cnt_d     = fail_cnt_q;
        timer_load     = 1'b0;
        timer_load_val = '0;

        case (state_q)
            IDLE: begin
                if (press) begin
                    code_d         = code;
                    mismatch_d     = !digit_ok;
                    entry_count_d  = 4'd1;
                    timer_load     = 1'b1;
                    timer_load_val = TIMER_W'(ENTRY_TIMEOUT);
                    state_d        = (SEQ_LEN == 1) ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                // A press arriving on the expiry cycle still counts.
                if (press) begin
                    mismatch_d     = mismatch_q | !digit_ok;
                    entry_count_d  = entry_count_q + 4'd1;
                    timer_load     = 1'b1;
                    timer_load_val = TIMER_W'(ENTRY_TIMEOUT);
                    if (last_press) state_d = CHECK;
                end else if (timer_expired) begin
                    mismatch_d    = 1'b0;
                    entry_count_d = '0;
                    state_d       = IDLE;
                end
            end
            CHECK: begin
                mismatch_d    = 1'b0;
                entry_count_d = '0;
                if (!mismatch_q) begin
                    fail_cnt_d     = '0;
                    timer_load     = 1'b1;
                    timer_load_val = TIMER_W'(OPEN_CYCLES);
                    state_d        = OPEN;
                end else if (fail_cnt_inc == FAIL_W'(MAX_FAILS)) begin
                    fail_cnt_d     = '0;
                    timer_load     = 1'b1;
                    timer_load_val = TIMER_W'(LOCKOUT_CYCLES);
                    state_d        = LOCKOUT;
                end else begin
                    fail_cnt_d = fail_cnt_inc;
                    state_d    = IDLE;
                end
            end
            OPEN: begin
                if (btn_pulse == 4'b0001 || timer_expired) state_d = IDLE;
            end
            LOCKOUT: begin
                if (timer_expired) state_d = IDLE;
            end
            default: begin
                mismatch_d    = 1'b0;
                entry_count_d = '0;
                state_d       = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        unlocked_d    = (state_d == OPEN);
        locked_out_d  = (state_d == LOCKOUT);
        error_pulse_d = (state_q == CHECK) && mismatch_q;
    end

    assign unlocked    = unlocked_q;
    assign error_pulse = error_pulse_q;
    assign locked_out  = locked_out_q;
    assign entry_count = entry_count_q;

endmodule
